// File: rtl/axi_lite_req_arbiter.sv
// Two-requester round-robin front end for an AXI4-Lite master: grants one
// single read/write at a time, sequences it to the master and bounds it with a watchdog.
module axi_lite_req_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  aclk,
    input  logic                  areset_n,
    // Handshake: a request transfers on a rising edge where valid && ready;
    // the payload must stay stable while valid is high and ready is low.
    input  logic                  req0_valid,
    input  logic                  req0_write,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  req0_ready,
    output logic                  req0_done,
    output logic [DATA_WIDTH-1:0] req0_rdata,
    output logic [1:0]            req0_resp,
    input  logic                  req1_valid,
    input  logic                  req1_write,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  req1_ready,
    output logic                  req1_done,
    output logic [DATA_WIDTH-1:0] req1_rdata,
    output logic [1:0]            req1_resp,
    output logic                  start_read,
    output logic                  start_write,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] data,
    input  logic                  mst_done,
    input  logic [DATA_WIDTH-1:0] mst_rdata,
    input  logic [1:0]            mst_resp,
    output logic                  busy,
    output logic                  grant,
    output logic [1:0]            o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                  r_state;
    state_t                  w_next;
    logic                    r_write;
    logic                    r_grant;
    logic                    r_last_grant;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic [1:0]              r_resp;
    logic [CNT_W-1:0]        r_cnt;
    logic                    w_pick;
    logic                    w_accept;
    logic                    w_timeout;

    // Winner selection: a lone requester wins; on a tie the one not served last wins.
    always_comb begin
        w_pick = 1'b0;
        if (req0_valid && req1_valid) begin
            w_pick = ~r_last_grant;
        end else if (req1_valid) begin
            w_pick = 1'b1;
        end
    end

    assign req0_ready = (r_state == S_IDLE) && req0_valid && !w_pick;
    assign req1_ready = (r_state == S_IDLE) && req1_valid &&  w_pick;
    assign w_accept   = req0_ready || req1_ready;
    assign w_timeout  = (r_cnt == CNT_LAST);

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (mst_done || w_timeout) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_write      <= 1'b0;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_addr       <= '0;
            r_data       <= '0;
            r_rdata      <= '0;
            r_resp       <= 2'b00;
            r_cnt        <= '0;
        end else begin
            if (w_accept) begin
                r_write      <= w_pick ? req1_write : req0_write;
                r_addr       <= w_pick ? req1_addr  : req0_addr;
                r_data       <= w_pick ? req1_wdata : req0_wdata;
                r_grant      <= w_pick;
                r_last_grant <= w_pick;
            end
            if (r_state == S_ISSUE) begin
                r_cnt <= '0;
            end else if (r_state == S_WAIT && !w_timeout) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            // A completion wins over a timeout landing on the same edge.
            if (r_state == S_WAIT) begin
                if (mst_done) begin
                    r_rdata <= r_write ? '0 : mst_rdata;
                    r_resp  <= mst_resp;
                end else if (w_timeout) begin
                    r_rdata <= '0;
                    r_resp  <= 2'b10;
                end
            end
        end
    end

    assign start_read  = (r_state == S_ISSUE) && !r_write;
    assign start_write = (r_state == S_ISSUE) &&  r_write;
    assign addr        = r_addr;
    assign data        = r_data;
    assign busy        = (r_state != S_IDLE);
    assign grant       = r_grant;
    assign o_dbg_state = r_state;

    assign req0_done  = (r_state == S_RESP) && !r_grant;
    assign req1_done  = (r_state == S_RESP) &&  r_grant;
    assign req0_rdata = req0_done ? r_rdata : '0;
    assign req1_rdata = req1_done ? r_rdata : '0;
    assign req0_resp  = req0_done ? r_resp  : 2'b00;
    assign req1_resp  = req1_done ? r_resp  : 2'b00;

endmodule

// File: tb/tb_axi_lite_req_arbiter.sv
// Directed bench for axi_lite_req_arbiter: a small master model answers start
// pulses, and completions are checked against a queue filled at acceptance.
module tb_axi_lite_req_arbiter;

    localparam logic [31:0] RD_MASK = 32'hA5A5_0000;

    logic        aclk = 1'b0;
    logic        areset_n = 1'b0;
    logic        req0_valid = 1'b0, req0_write = 1'b0;
    logic [31:0] req0_addr = '0, req0_wdata = '0;
    logic        req0_ready, req0_done;
    logic [31:0] req0_rdata;
    logic [1:0]  req0_resp;
    logic        req1_valid = 1'b0, req1_write = 1'b0;
    logic [31:0] req1_addr = '0, req1_wdata = '0;
    logic        req1_ready, req1_done;
    logic [31:0] req1_rdata;
    logic [1:0]  req1_resp;
    logic        start_read, start_write;
    logic [31:0] addr, data;
    logic        mst_done = 1'b0;
    logic [31:0] mst_rdata = '0;
    logic [1:0]  mst_resp = 2'b00;
    logic        busy, grant;
    logic [1:0]  o_dbg_state;

    int checks = 0;
    int failures = 0;

    // {port, resp, rdata}
    logic [34:0] exp_q[$];

    axi_lite_req_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)
    ) dut (
        .aclk(aclk), .areset_n(areset_n),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_done(req0_done),
        .req0_rdata(req0_rdata), .req0_resp(req0_resp),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_done(req1_done),
        .req1_rdata(req1_rdata), .req1_resp(req1_resp),
        .start_read(start_read), .start_write(start_write), .addr(addr), .data(data),
        .mst_done(mst_done), .mst_rdata(mst_rdata), .mst_resp(mst_resp),
        .busy(busy), .grant(grant), .o_dbg_state(o_dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 aclk = ~aclk;

    initial begin
        #400000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- master model ----------------
    int          mst_delay = 0;
    logic        mst_ovr_en = 1'b0;
    logic [31:0] mst_ovr_rdata = '0;
    logic [1:0]  mst_ovr_resp = 2'b00;
    logic        mst_pend = 1'b0;
    int          mst_cnt = 0;
    logic [31:0] mst_addr = '0;

    always @(negedge aclk) begin
        mst_done = 1'b0;
        if (!areset_n) begin
            mst_pend = 1'b0;
        end else if (mst_pend && mst_cnt == 0) begin
            mst_done  = 1'b1;
            mst_rdata = mst_ovr_en ? mst_ovr_rdata : (mst_addr ^ RD_MASK);
            mst_resp  = mst_ovr_en ? mst_ovr_resp : 2'b00;
            mst_pend  = 1'b0;
        end else if (mst_pend) begin
            mst_cnt--;
        end
        if (areset_n && (start_read || start_write)) begin
            mst_pend = 1'b1;
            mst_cnt  = mst_delay;
            mst_addr = addr;
        end
    end

    // ---------------- scoreboard ----------------
    logic [34:0] sb_exp;
    always @(negedge aclk) begin
        if (areset_n && (req0_done || req1_done)) begin
            check("done_exclusive", {req1_done, req0_done} == 2'b11, 1'b0);
            check("done_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                sb_exp = exp_q.pop_front();
                check("done_port", req1_done, sb_exp[34]);
                check("done_rdata", req1_done ? req1_rdata : req0_rdata, sb_exp[31:0]);
                check("done_resp", req1_done ? req1_resp : req0_resp, sb_exp[33:32]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    logic model_last = 1'b1;

    // Called at a negedge; returns at the negedge one cycle after the start pulse.
    task automatic single_req(input logic port, input logic wr, input logic [31:0] a,
                              input logic [31:0] d, input logic [31:0] exp_rd,
                              input logic [1:0] exp_rs);
        int n;
        if (port) begin
            req1_valid = 1'b1; req1_write = wr; req1_addr = a; req1_wdata = d;
        end else begin
            req0_valid = 1'b1; req0_write = wr; req0_addr = a; req0_wdata = d;
        end
        n = 0;
        #1;
        while (!(port ? req1_ready : req0_ready) && n < 20) begin
            @(negedge aclk); #1; n++;
        end
        check("ready_seen", n < 20, 1'b1);
        exp_q.push_back({port, exp_rs, exp_rd});
        model_last = port;
        @(posedge aclk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge aclk);
        check("issue_start_write", start_write, wr);
        check("issue_start_read", start_read, !wr);
        check("issue_addr", addr, a);
        if (wr) check("issue_data", data, d);
        check("issue_grant", grant, port);
        check("issue_busy", busy, 1'b1);
        @(negedge aclk);
        check("start_one_cycle", {start_write, start_read}, 2'b00);
    endtask

    task automatic wait_done(input logic port, output int lat);
        lat = 1;
        while (!(port ? req1_done : req0_done) && lat < 60) begin
            @(negedge aclk); lat++;
        end
        check("done_within_bound", lat < 60, 1'b1);
    endtask

    // ---------------- directed sequence ----------------
    int   lat;
    int   n;
    logic w;
    logic seen;
    logic [31:0] a;

    initial begin
        repeat (3) @(negedge aclk);
        check("rst_busy", busy, 1'b0);
        check("rst_grant", grant, 1'b0);
        check("rst_state", o_dbg_state, 2'd0);
        check("rst_outs", {start_read, start_write, req0_done, req1_done, req0_ready, req1_ready}, 6'd0);
        check("rst_addr_data", {addr, data}, 64'd0);
        areset_n = 1'b1;
        @(negedge aclk);

        // Read on port 0
        mst_delay = 0; mst_ovr_en = 1'b1; mst_ovr_rdata = 32'hDEADBEEF; mst_ovr_resp = 2'b00;
        single_req(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 2'b00);
        wait_done(1'b0, lat);
        check("rd_latency", lat, 2);
        @(negedge aclk);
        check("rd_busy_after", busy, 1'b0);

        // Write on port 1: master rdata must be discarded
        mst_ovr_rdata = 32'hFFFF_FFFF;
        single_req(1'b1, 1'b1, 32'h20, 32'h12345678, 32'h0, 2'b00);
        wait_done(1'b1, lat);
        check("wr_latency", lat, 2);
        @(negedge aclk);

        // Both valid continuously: alternating grants
        mst_ovr_en = 1'b0;
        req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 32'h100;
        req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 32'h200;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            #1;
            while (!(req0_ready || req1_ready) && n < 20) begin
                @(negedge aclk); #1; n++;
            end
            check("tie_ready_seen", n < 20, 1'b1);
            w = ~model_last;
            check("tie_winner", {req1_ready, req0_ready}, w ? 2'b10 : 2'b01);
            a = w ? req1_addr : req0_addr;
            exp_q.push_back({w, 2'b00, a ^ RD_MASK});
            model_last = w;
            @(posedge aclk); #1;
            if (w) req1_addr = req1_addr + 32'h10;
            else   req0_addr = req0_addr + 32'h10;
            @(negedge aclk);
            check("tie_grant", grant, w);
            check("tie_addr", addr, a);
            @(negedge aclk);
            wait_done(w, lat);
            check("tie_latency", lat, 2);
            @(negedge aclk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge aclk);

        // Watchdog: master answers only after the timeout has fired
        mst_delay = 12; mst_ovr_en = 1'b1; mst_ovr_rdata = 32'h5555_AAAA; mst_ovr_resp = 2'b00;
        single_req(1'b0, 1'b0, 32'h30, 32'h0, 32'h0, 2'b10);
        wait_done(1'b0, lat);
        check("timeout_latency", lat, 9);
        seen = 1'b0;
        repeat (10) begin
            @(negedge aclk);
            seen = seen | req0_done | req1_done;
        end
        check("late_mst_done_ignored", seen, 1'b0);
        check("late_busy", busy, 1'b0);

        // Reset during WAIT aborts the transaction
        mst_delay = 6; mst_ovr_en = 1'b0;
        single_req(1'b1, 1'b0, 32'h300, 32'h0, 32'h300 ^ RD_MASK, 2'b00);
        @(negedge aclk);
        check("pre_rst_wait", o_dbg_state, 2'd2);
        areset_n = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_grant", grant, 1'b0);
        check("midrst_state", o_dbg_state, 2'd0);
        check("midrst_outs", {start_read, start_write, req0_done, req1_done, req0_ready, req1_ready}, 6'd0);
        check("midrst_addr_data", {addr, data}, 64'd0);
        @(negedge aclk);
        check("midrst_no_done", {req0_done, req1_done}, 2'b00);
        mst_delay = 0;
        model_last = 1'b1;
        req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 32'h400;
        req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 32'h500;
        areset_n = 1'b1;
        #1;
        check("postrst_tie_winner", {req1_ready, req0_ready}, 2'b01);
        exp_q.push_back({1'b0, 2'b00, 32'h400 ^ RD_MASK});
        model_last = 1'b0;
        @(posedge aclk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge aclk);
        check("postrst_grant", grant, 1'b0);
        check("postrst_start", start_read, 1'b1);
        check("postrst_addr", addr, 32'h400);
        @(negedge aclk);
        wait_done(1'b0, lat);
        check("postrst_latency", lat, 2);
        @(negedge aclk);

        // Error response from the master propagates with its rdata
        mst_delay = 2; mst_ovr_en = 1'b1; mst_ovr_rdata = 32'hCAFEF00D; mst_ovr_resp = 2'b10;
        single_req(1'b0, 1'b0, 32'h44, 32'h0, 32'hCAFEF00D, 2'b10);
        wait_done(1'b0, lat);
        check("slverr_latency", lat, 4);
        repeat (3) @(negedge aclk);

        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
